aes_subbytes_seq: RTL and testbench
===================================

Name: aes_subbytes_seq

Overview:
Byte-serial SubBytes/InvSubBytes controller. It time-shares one instance of the existing combinational multiplicative_inv block (ports b, inv_b; test_result left unconnected) across all bytes of an AES state, wrapping it with the forward or inverse affine transform. The block accepts a state word over a valid/ready handshake, processes one byte per clock, and then holds the result until the consumer accepts it. It sits between the round controller and the round datapath as a low-area alternative to sixteen parallel S-boxes.

Parameters:
BYTES_P, 16, number of bytes per state word; data width is 8*BYTES_P; must be >= 2.

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
v_i  input  1  input state valid
mode_i  input  1  0 = SubBytes (forward), 1 = InvSubBytes; sampled at accept
state_i  input  8*BYTES_P  input state; byte k = state_i[8k+7:8k]
ready_o  output  1  block can accept a new state
v_o  output  1  result valid
state_o  output  8*BYTES_P  substituted state, same byte ordering
ready_i  input  1  consumer accepts result

Behaviour:
- Reset (reset_i=1 at a clock edge): FSM goes to IDLE, counter=0, state_o=0, v_o=0, ready_o=1 after the edge. Reset mid-operation discards the in-flight state; no partial result is ever presented.
- FSM states:
  - IDLE: ready_o=1, v_o=0. On v_i&ready_o, latch state_i and mode_i, clear counter, go to BUSY.
  - BUSY: ready_o=0, v_o=0. Each cycle, byte[cnt] of the latched state goes through the datapath and the result is written into result byte cnt. cnt increments by 1. At cnt==BYTES_P-1, write the last byte, go to DONE, and clear cnt (no wrap past BYTES_P-1).
  - DONE: v_o=1, ready_o=0, state_o stable. On ready_i, go to IDLE.
- Latency: accept edge at cycle 0; BUSY spans cycles 0..BYTES_P-1; v_o rises after edge BYTES_P (the 17th cycle for BYTES_P=16).
- Throughput: one state per BYTES_P+2 cycles with ready_i held high. No accept in the same cycle as a result handshake, since ready_o=0 in DONE.
- Byte datapath (combinational, one byte per cycle):
  - Forward: x = inv(byte); out = x ^ rotl(x,1) ^ rotl(x,2) ^ rotl(x,3) ^ rotl(x,4) ^ 8'h63.
  - Inverse: y = rotl(byte,1) ^ rotl(byte,3) ^ rotl(byte,6) ^ 8'h05; out = inv(y).
  - inv(0)=0 per the multiplicative_inv convention. All arithmetic is 8-bit, with rotl modulo 8.
- A single multiplicative_inv instance is required. Its input mux selects the raw byte (forward) or the inverse-affine output (inverse).
- state_o is registered; it holds the previous result outside DONE (0 after reset). Consumers use only state_o qualified by v_o.
- v_i is ignored in BUSY and DONE. The producer must hold v_i/state_i until ready_o.
- ready_i is ignored outside DONE.
- Counter width is $clog2(BYTES_P).

Test Plan:
- Reset, then forward mode with state_i = 128'h0 -> after 17 cycles v_o=1, state_o = {16{8'h63}}; ready_o=0 throughout BUSY.
- Forward, state_i bytes k=0..3 = 8'h00, 8'h01, 8'h53, 8'hff (rest 8'h00) -> state_o bytes 0..3 = 8'h63, 8'h7c, 8'hed, 8'h16; remaining bytes 8'h63.
- Inverse, state_i bytes 0..2 = 8'h63, 8'hed, 8'h16 (rest 8'h63) -> state_o bytes 0..2 = 8'h00, 8'h53, 8'hff; rest 8'h00. Then forward on that output restores the original input (round trip).
- Backpressure: hold ready_i=0 for 5 cycles in DONE -> v_o and state_o stay stable, ready_o=0, and a new v_i is not accepted; ready_i=1 -> IDLE next cycle, ready_o=1.
- Assert reset_i at byte 7 of BUSY -> next cycle IDLE, v_o=0, state_o=0. A following transaction with 128'h0 yields {16{8'h63}} with correct latency.
- Back-to-back: v_i held high with ready_i=1 for two states -> second accept occurs exactly BYTES_P+2 cycles after the first, and both results are correct.

Source files
------------

// File: rtl/aes_subbytes_seq.sv
// Byte-serial AES SubBytes / InvSubBytes engine.
// One multiplicative-inverse block is shared across all bytes of the state;
// the forward or inverse affine transform is wrapped around it per byte.
// A latched state word is processed one byte per clock and the finished
// result is held on state_o until the consumer takes it.

// Combinational GF(2^8) multiplicative inverse (AES field, x^8+x^4+x^3+x+1).
// inv(0) is defined as 0. test_result flags that b * inv_b == 1 (or b == 0).
module multiplicative_inv (
   input  logic [7:0] b,
   output logic [7:0] inv_b,
   output logic       test_result
);

   // b^254 == b^-1 for every non-zero b in GF(2^8)
   localparam logic [7:0] INV_EXP_P = 8'hFE;

   // GF(2^8) multiply with reduction by the AES polynomial
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            p = p ^ aa;
         end else begin
            p = p;
         end
         if (aa[7]) begin
            aa = {aa[6:0], 1'b0} ^ 8'h1B;
         end else begin
            aa = {aa[6:0], 1'b0};
         end
      end
      return p;
   endfunction

   // Square-and-multiply exponentiation b^254
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (INV_EXP_P[i]) begin
            r = gf_mul(r, x);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Inverse and its self-check
   always_comb begin
      inv_b       = gf_inv(b);
      test_result = (b == 8'h00) || (gf_mul(b, inv_b) == 8'h01);
   end

endmodule

module aes_subbytes_seq #(
   parameter int BYTES_P = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   v_i,
   input  logic                   mode_i,
   input  logic [8*BYTES_P-1:0]   state_i,
   output logic                   ready_o,
   output logic                   v_o,
   output logic [8*BYTES_P-1:0]   state_o,
   input  logic                   ready_i
);

   localparam int DW_P  = 8 * BYTES_P;
   localparam int CNT_W = $clog2(BYTES_P);
   localparam logic [CNT_W-1:0] CNT_LAST_P = CNT_W'(BYTES_P - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // 8-bit rotate left, amount modulo 8
   function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
      logic [15:0] dbl;
      dbl = {x, x} << (n % 8);
      return dbl[15:8];
   endfunction

   // Forward affine transform applied after inversion
   function automatic logic [7:0] affine_fwd(input logic [7:0] x);
      return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
   endfunction

   // Inverse affine transform applied before inversion
   function automatic logic [7:0] affine_inv(input logic [7:0] x);
      return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
   endfunction

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              mode_q,  mode_d;
   // Working copy of the state: bytes are overwritten in place once consumed
   logic [DW_P-1:0]   work_q,  work_d;
   logic [DW_P-1:0]   res_q,   res_d;
   logic              ready_q, ready_d;
   logic              v_q,     v_d;

   logic [7:0]        cur_byte_s;
   logic [7:0]        inv_in_s;
   logic [7:0]        inv_out_s;
   logic [7:0]        sub_byte_s;

   // Byte datapath: select current byte, wrap the shared inverter with the affine stages
   always_comb begin
      cur_byte_s = work_q[8*int'(cnt_q) +: 8];
      if (mode_q) begin
         inv_in_s   = affine_inv(cur_byte_s);
         sub_byte_s = inv_out_s;
      end else begin
         inv_in_s   = cur_byte_s;
         sub_byte_s = affine_fwd(inv_out_s);
      end
   end

   multiplicative_inv u_inv (
      .b           (inv_in_s),
      .inv_b       (inv_out_s),
      .test_result ()
   );

   // Next-state logic for the FSM, counter, working state and result
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      work_d  = work_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (v_i && ready_q) begin
               work_d  = state_i;
               mode_d  = mode_i;
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            work_d[8*int'(cnt_q) +: 8] = sub_byte_s;
            if (cnt_q == CNT_LAST_P) begin
               cnt_d   = {CNT_W{1'b0}};
               res_d   = work_d;
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (ready_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Handshake outputs follow the next FSM state so they can be registered
   always_comb begin
      ready_d = (state_d == ST_IDLE);
      v_d     = (state_d == ST_DONE);
   end

   // State registers with synchronous reset; reset drops any in-flight work
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         mode_q  <= 1'b0;
         work_q  <= {DW_P{1'b0}};
         res_q   <= {DW_P{1'b0}};
         ready_q <= 1'b1;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         work_q  <= work_d;
         res_q   <= res_d;
         ready_q <= ready_d;
         v_q     <= v_d;
      end
   end

   assign ready_o = ready_q;
   assign v_o     = v_q;
   assign state_o = res_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Directed self-checking bench for aes_subbytes_seq (BYTES_P = 16).
module tb_aes_subbytes_seq;

   localparam int BYTES_P = 16;
   localparam int DW = 8 * BYTES_P;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          v_i;
   logic          mode_i;
   logic [DW-1:0] state_i;
   logic          ready_o;
   logic          v_o;
   logic [DW-1:0] state_o;
   logic          ready_i;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [DW-1:0] ALL63   = {16{8'h63}};
   localparam logic [DW-1:0] FWD_IN  = 128'h00000000_00000000_00000000_ff530100;
   localparam logic [DW-1:0] FWD_EXP = 128'h63636363_63636363_63636363_16ed7c63;
   localparam logic [DW-1:0] INV_IN  = 128'h63636363_63636363_63636363_6316ed63;
   localparam logic [DW-1:0] INV_EXP = 128'h00000000_00000000_00000000_00ff5300;

   aes_subbytes_seq #(.BYTES_P(BYTES_P)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (v_i),
      .mode_i  (mode_i),
      .state_i (state_i),
      .ready_o (ready_o),
      .v_o     (v_o),
      .state_o (state_o),
      .ready_i (ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic step;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
   endtask

   // Accept one state, check BUSY ready_o, latency and result; leaves DUT in DONE
   task automatic run_txn(input string tag, input logic m, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_v);
      int  lat;
      logic busy_ok;
      for (int i = 0; i < 50 && !ready_o; i++) step;
      chk({tag, "_ready"}, DW'(ready_o), DW'(1));
      v_i = 1'b1; mode_i = m; state_i = d;
      step;                       // accept edge
      v_i = 1'b0;
      lat = 0; busy_ok = 1'b1;
      while (!v_o && lat < 40) begin
         step;
         lat++;
         if (!v_o && ready_o) busy_ok = 1'b0;
      end
      chk({tag, "_latency"}, DW'(lat), DW'(BYTES_P));
      chk({tag, "_busy_ready0"}, DW'(busy_ok), DW'(1));
      chk({tag, "_result"}, state_o, exp_v);
   endtask

   // Complete the result handshake and confirm return to IDLE
   task automatic release_txn(input string tag);
      ready_i = 1'b1;
      step;
      ready_i = 1'b0;
      chk({tag, "_rel_v"}, DW'(v_o), DW'(0));
      chk({tag, "_rel_ready"}, DW'(ready_o), DW'(1));
   endtask

   initial begin
      logic [DW-1:0] held;
      logic          bp_v_ok, bp_s_ok, bp_r_ok;
      int            cyc, nacc, nres;
      int            acc_t [2];
      logic [DW-1:0] res [2];

      reset_i = 1'b1; v_i = 1'b0; mode_i = 1'b0; state_i = '0; ready_i = 1'b0;
      step; step;
      chk("rst_ready", DW'(ready_o), DW'(1));
      chk("rst_v", DW'(v_o), DW'(0));
      chk("rst_state", state_o, '0);
      reset_i = 1'b0;
      step;

      // forward, all-zero state
      run_txn("fwd_zero", 1'b0, '0, ALL63);
      release_txn("fwd_zero");

      // forward, mixed bytes, then backpressure in DONE
      run_txn("fwd_mix", 1'b0, FWD_IN, FWD_EXP);
      held = state_o;
      v_i = 1'b1; mode_i = 1'b1; state_i = 128'hdeadbeef;
      bp_v_ok = 1'b1; bp_s_ok = 1'b1; bp_r_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step;
         if (v_o !== 1'b1) bp_v_ok = 1'b0;
         if (state_o !== held) bp_s_ok = 1'b0;
         if (ready_o !== 1'b0) bp_r_ok = 1'b0;
      end
      chk("bp_v_stable", DW'(bp_v_ok), DW'(1));
      chk("bp_state_stable", DW'(bp_s_ok), DW'(1));
      chk("bp_ready0", DW'(bp_r_ok), DW'(1));
      v_i = 1'b0;
      release_txn("bp");
      chk("bp_state_held", state_o, FWD_EXP);

      // inverse, then forward round trip
      run_txn("inv", 1'b1, INV_IN, INV_EXP);
      held = state_o;
      release_txn("inv");
      run_txn("round_trip", 1'b0, held, INV_IN);
      release_txn("round_trip");

      // reset in the middle of BUSY
      v_i = 1'b1; mode_i = 1'b0; state_i = 128'h0123456789abcdef_fedcba9876543210;
      step;
      v_i = 1'b0;
      for (int i = 0; i < 7; i++) step;
      reset_i = 1'b1;
      step;
      reset_i = 1'b0;
      chk("midrst_v", DW'(v_o), DW'(0));
      chk("midrst_state", state_o, '0);
      chk("midrst_ready", DW'(ready_o), DW'(1));
      run_txn("post_rst", 1'b0, '0, ALL63);
      release_txn("post_rst");

      // back-to-back with v_i and ready_i held high
      v_i = 1'b1; mode_i = 1'b0; state_i = '0; ready_i = 1'b1;
      cyc = 0; nacc = 0; nres = 0;
      acc_t[0] = 0; acc_t[1] = 0; res[0] = '0; res[1] = '0;
      while (nres < 2 && cyc < 80) begin
         if (v_i && ready_o && nacc < 2) begin
            acc_t[nacc] = cyc;
            nacc++;
         end
         if (v_o && ready_i) begin
            res[nres] = state_o;
            nres++;
         end
         step;
         cyc++;
         if (nacc == 1) state_i = FWD_IN;
         if (nacc == 2) v_i = 1'b0;
      end
      ready_i = 1'b0;
      chk("b2b_results_seen", DW'(nres), DW'(2));
      chk("b2b_spacing", DW'(acc_t[1] - acc_t[0]), DW'(BYTES_P + 2));
      chk("b2b_res0", res[0], ALL63);
      chk("b2b_res1", res[1], FWD_EXP);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
